morse_timed_decoder: RTL and testbench



---
 rtl/morse_timed_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_morse_timed_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_timed_decoder.sv
// Morse key decoder: times key presses and gaps in tick units, classifies dots/dashes
// and letter/word gaps, and assembles each letter's element pattern for lookup.
module morse_timed_decoder #(
   parameter int GLITCH_TICKS = 2,
   parameter int DASH_TICKS   = 120,
   parameter int LG_TICKS     = 120,
   parameter int WG_TICKS     = 300,
   parameter int MAX_SYM      = 6,
   parameter int CNT_W        = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tick,
   input  logic                         b,
   output logic                         dot_out,
   output logic                         dash_out,
   output logic                         lg,
   output logic                         wg,
   output logic                         letter_valid,
   output logic [MAX_SYM-1:0]           code,
   output logic [$clog2(MAX_SYM+1)-1:0] len,
   output logic                         overflow
);

   localparam int LEN_W = $clog2(MAX_SYM + 1);
   localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_TICKS);
   localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_TICKS);
   localparam logic [CNT_W-1:0] LG_C     = CNT_W'(LG_TICKS);
   localparam logic [CNT_W-1:0] WG_C     = CNT_W'(WG_TICKS);
   localparam logic [LEN_W-1:0] MAX_C    = LEN_W'(MAX_SYM);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2,
      ST_LGAP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 b_meta_q, b_s_q;
   logic [CNT_W-1:0]     mark_cnt_q, mark_cnt_d;
   logic [CNT_W-1:0]     space_cnt_q, space_cnt_d;
   logic [MAX_SYM-1:0]   sr_q, sr_d;
   logic [LEN_W-1:0]     len_acc_q, len_acc_d;
   logic                 ovf_acc_q, ovf_acc_d;
   logic [MAX_SYM-1:0]   code_q, code_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 ovf_q, ovf_d;
   logic                 dot_q, dot_d;
   logic                 dash_q, dash_d;
   logic                 lg_q, lg_d;
   logic                 wg_q, wg_d;
   logic                 lv_q, lv_d;

   logic                 mark_glitch_s;
   logic                 mark_dash_s;
   logic [CNT_W-1:0]     space_inc_s;
   logic                 lg_hit_s;
   logic                 wg_hit_s;
   logic                 len_full_s;
   logic                 len_zero_s;

   // A key transition takes priority over a tick in the same cycle, so hits need b_s low.
   assign mark_glitch_s = (mark_cnt_q < GLITCH_C);
   assign mark_dash_s   = (mark_cnt_q >= DASH_C);
   assign space_inc_s   = space_cnt_q + CNT_W'(1);
   assign lg_hit_s      = (state_q == ST_SPACE) && !b_s_q && tick && (space_inc_s == LG_C);
   assign wg_hit_s      = (state_q == ST_LGAP) && !b_s_q && tick && (space_inc_s == WG_C);
   assign len_full_s    = (len_acc_q == MAX_C);
   assign len_zero_s    = (len_acc_q == LEN_W'(0));

   // Key synchronizer, FSM state, counters, letter accumulator and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         b_meta_q    <= 1'b0;
         b_s_q       <= 1'b0;
         state_q     <= ST_IDLE;
         mark_cnt_q  <= CNT_W'(0);
         space_cnt_q <= CNT_W'(0);
         sr_q        <= MAX_SYM'(0);
         len_acc_q   <= LEN_W'(0);
         ovf_acc_q   <= 1'b0;
         code_q      <= MAX_SYM'(0);
         len_q       <= LEN_W'(0);
         ovf_q       <= 1'b0;
         dot_q       <= 1'b0;
         dash_q      <= 1'b0;
         lg_q        <= 1'b0;
         wg_q        <= 1'b0;
         lv_q        <= 1'b0;
      end else begin
         b_meta_q    <= b;
         b_s_q       <= b_meta_q;
         state_q     <= state_d;
         mark_cnt_q  <= mark_cnt_d;
         space_cnt_q <= space_cnt_d;
         sr_q        <= sr_d;
         len_acc_q   <= len_acc_d;
         ovf_acc_q   <= ovf_acc_d;
         code_q      <= code_d;
         len_q       <= len_d;
         ovf_q       <= ovf_d;
         dot_q       <= dot_d;
         dash_q      <= dash_d;
         lg_q        <= lg_d;
         wg_q        <= wg_d;
         lv_q        <= lv_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (b_s_q) state_d = ST_MARK;
            else       state_d = ST_IDLE;
         end
         ST_MARK: begin
            if (b_s_q)                          state_d = ST_MARK;
            else if (mark_glitch_s && len_zero_s) state_d = ST_IDLE;
            else                                state_d = ST_SPACE;
         end
         ST_SPACE: begin
            if (b_s_q)         state_d = ST_MARK;
            else if (lg_hit_s) state_d = ST_LGAP;
            else               state_d = ST_SPACE;
         end
         ST_LGAP: begin
            if (b_s_q)         state_d = ST_MARK;
            else if (wg_hit_s) state_d = ST_IDLE;
            else               state_d = ST_LGAP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters, element accumulation, letter emission and pulse generation.
   always_comb begin
      mark_cnt_d  = CNT_W'(0);
      space_cnt_d = space_cnt_q;
      sr_d        = sr_q;
      len_acc_d   = len_acc_q;
      ovf_acc_d   = ovf_acc_q;
      code_d      = code_q;
      len_d       = len_q;
      ovf_d       = ovf_q;
      dot_d       = 1'b0;
      dash_d      = 1'b0;
      lg_d        = 1'b0;
      wg_d        = 1'b0;
      lv_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            space_cnt_d = CNT_W'(0);
         end
         ST_MARK: begin
            if (b_s_q) begin
               if (tick && (mark_cnt_q != DASH_C)) mark_cnt_d = mark_cnt_q + CNT_W'(1);
               else                                mark_cnt_d = mark_cnt_q;
            end else begin
               space_cnt_d = CNT_W'(0);
               if (mark_glitch_s) begin
                  dot_d  = 1'b0;
                  dash_d = 1'b0;
               end else begin
                  dot_d  = !mark_dash_s;
                  dash_d = mark_dash_s;
                  // A full letter keeps its first MAX_SYM elements and only flags the rest.
                  if (len_full_s) begin
                     ovf_acc_d = 1'b1;
                  end else begin
                     sr_d      = {sr_q[MAX_SYM-2:0], mark_dash_s};
                     len_acc_d = len_acc_q + LEN_W'(1);
                  end
               end
            end
         end
         ST_SPACE: begin
            if (b_s_q) begin
               space_cnt_d = space_cnt_q;
            end else if (tick) begin
               space_cnt_d = space_inc_s;
               if (lg_hit_s) begin
                  lg_d      = 1'b1;
                  lv_d      = 1'b1;
                  code_d    = sr_q;
                  len_d     = len_acc_q;
                  ovf_d     = ovf_acc_q;
                  sr_d      = MAX_SYM'(0);
                  len_acc_d = LEN_W'(0);
                  ovf_acc_d = 1'b0;
               end else begin
                  lg_d = 1'b0;
               end
            end else begin
               space_cnt_d = space_cnt_q;
            end
         end
         ST_LGAP: begin
            if (b_s_q) begin
               space_cnt_d = space_cnt_q;
            end else if (tick) begin
               space_cnt_d = space_inc_s;
               wg_d        = wg_hit_s;
            end else begin
               space_cnt_d = space_cnt_q;
            end
         end
         default: begin
            space_cnt_d = CNT_W'(0);
         end
      endcase
   end

   assign dot_out      = dot_q;
   assign dash_out     = dash_q;
   assign lg           = lg_q;
   assign wg           = wg_q;
   assign letter_valid = lv_q;
   assign code         = code_q;
   assign len          = len_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_morse_timed_decoder.sv
// Bench for morse_timed_decoder: directed scenarios plus random key traffic, checked
// every cycle against an element-queue model of the key timing rules.
`timescale 1ns/1ps
module tb_morse_timed_decoder;

   localparam int GL = 2;
   localparam int DA = 4;
   localparam int LGT = 4;
   localparam int WGT = 10;
   localparam int MS = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       b;
   logic       dot_out, dash_out, lg, wg, letter_valid, overflow;
   logic [5:0] code;
   logic [2:0] len;

   always #5 clk = ~clk;

   morse_timed_decoder #(
      .GLITCH_TICKS(GL), .DASH_TICKS(DA), .LG_TICKS(LGT), .WG_TICKS(WGT),
      .MAX_SYM(MS), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .b(b),
      .dot_out(dot_out), .dash_out(dash_out), .lg(lg), .wg(wg),
      .letter_valid(letter_valid), .code(code), .len(len), .overflow(overflow)
   );

   int total = 0;
   int bad = 0;

   // Model: synchronizer delay, then runs of key level measured in ticks.
   logic m_syn1, m_syn2;
   bit   holding, gap_open, wg_armed;
   int   press_t, gap_t;
   bit   elems[$];
   logic e_dot, e_dash, e_lg, e_wg, e_lv, e_ovf;
   logic [5:0] e_code;
   logic [2:0] e_len;

   int cyc_n = 0;
   int n_dot, n_dash, n_lg, n_wg, n_lv;
   int lg_at, wg_at;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_n);
      end
   endtask

   task automatic model_clear();
      m_syn1 = 1'b0; m_syn2 = 1'b0;
      holding = 1'b0; gap_open = 1'b0; wg_armed = 1'b0;
      press_t = 0; gap_t = 0;
      elems.delete();
      e_dot = 1'b0; e_dash = 1'b0; e_lg = 1'b0; e_wg = 1'b0; e_lv = 1'b0;
      e_ovf = 1'b0; e_code = 6'd0; e_len = 3'd0;
   endtask

   task automatic model_emit();
      int n;
      n = (elems.size() > MS) ? MS : elems.size();
      e_code = 6'd0;
      for (int i = 0; i < n; i++) e_code = {e_code[4:0], elems[i]};
      e_len = 3'(n);
      e_ovf = (elems.size() > MS);
      e_lg = 1'b1;
      e_lv = 1'b1;
      elems.delete();
   endtask

   task automatic model_advance(input logic bs, input logic tk);
      e_dot = 1'b0; e_dash = 1'b0; e_lg = 1'b0; e_wg = 1'b0; e_lv = 1'b0;
      if (holding) begin
         if (!bs) begin
            holding = 1'b0;
            gap_t = 0;
            if (press_t < GL) begin
               gap_open = (elems.size() > 0);
            end else begin
               elems.push_back(press_t >= DA);
               if (press_t >= DA) e_dash = 1'b1;
               else               e_dot = 1'b1;
               gap_open = 1'b1;
            end
         end else if (tk) begin
            press_t++;
         end
      end else if (gap_open || wg_armed) begin
         if (bs) begin
            holding = 1'b1; press_t = 0; gap_open = 1'b0; wg_armed = 1'b0;
         end else if (tk) begin
            gap_t++;
            if (gap_open && gap_t == LGT) begin
               model_emit();
               gap_open = 1'b0;
               wg_armed = 1'b1;
            end else if (wg_armed && gap_t == WGT) begin
               e_wg = 1'b1;
               wg_armed = 1'b0;
            end
         end
      end else if (bs) begin
         holding = 1'b1; press_t = 0;
      end
   endtask

   task automatic step(input logic nb, input logic nt);
      b = nb;
      tick = nt;
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         model_advance(m_syn2, tick);
         m_syn2 = m_syn1;
         m_syn1 = b;
      end
      @(negedge clk);
      cyc_n++;
      check("pulses", 32'({dot_out, dash_out, lg, wg, letter_valid}),
            32'({e_dot, e_dash, e_lg, e_wg, e_lv}));
      check("letter", 32'({overflow, len, code}), 32'({e_ovf, e_len, e_code}));
      n_dot += int'(dot_out);
      n_dash += int'(dash_out);
      n_lg += int'(lg);
      n_wg += int'(wg);
      n_lv += int'(letter_valid);
      if (lg) lg_at = cyc_n;
      if (wg) wg_at = cyc_n;
   endtask

   task automatic press(input int n);
      repeat (n + 1) step(1'b1, 1'b1);
   endtask

   task automatic gap(input int n);
      repeat (n + 1) step(1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b1);
   endtask

   task automatic clr_counts();
      n_dot = 0; n_dash = 0; n_lg = 0; n_wg = 0; n_lv = 0;
      lg_at = 0; wg_at = 0;
   endtask

   // Assert reset between clock edges; outputs must drop without waiting for a clock.
   task automatic reset_mid();
      #2;
      reset = 1'b1;
      b = 1'b0;
      #1;
      check("reset_async", 32'({dot_out, dash_out, lg, wg, letter_valid, overflow, len, code}), 32'd0);
      model_clear();
      @(negedge clk);
      step(1'b0, 1'b1);
      reset = 1'b0;
   endtask

   logic lvl;
   int   run_len, dens;

   initial begin
      reset = 1'b1;
      b = 1'b0;
      tick = 1'b0;
      model_clear();
      clr_counts();
      repeat (2) @(negedge clk);
      check("reset_state", 32'({dot_out, dash_out, lg, wg, letter_valid, overflow, len, code}), 32'd0);
      reset = 1'b0;
      idle(3);

      // Single dot, then wg six ticks after lg.
      clr_counts();
      press(2);
      idle(20);
      check("dot_count", 32'(n_dot), 32'd1);
      check("dot_len", 32'(len), 32'd1);
      check("dot_code", 32'(code), 32'd0);
      check("dot_lg_to_wg", 32'(wg_at - lg_at), 32'd6);
      check("dot_wg_count", 32'(n_wg), 32'd1);

      // Letter K: dash dot dash.
      clr_counts();
      press(5); gap(2); press(2); gap(2); press(5);
      idle(20);
      check("k_dash_count", 32'(n_dash), 32'd2);
      check("k_dot_count", 32'(n_dot), 32'd1);
      check("k_code", 32'(code), 32'b000101);
      check("k_model_code", 32'(e_code), 32'b000101);
      check("k_len", 32'(len), 32'd3);
      check("k_ovf", 32'(overflow), 32'd0);

      // Glitch is dropped, a following dot stands alone.
      clr_counts();
      press(1);
      idle(10);
      check("glitch_pulses", 32'(n_dot + n_dash + n_lg + n_wg), 32'd0);
      press(2);
      idle(20);
      check("glitch_then_dot_len", 32'(len), 32'd1);

      // Seven dots overflow a six-element letter; the next letter is clean.
      clr_counts();
      repeat (7) begin
         press(2);
         gap(1);
      end
      idle(20);
      check("ovf_dot_count", 32'(n_dot), 32'd7);
      check("ovf_letter", 32'({overflow, len, code}), 32'({1'b1, 3'd6, 6'd0}));
      check("ovf_model", 32'({e_ovf, e_len}), 32'({1'b1, 3'd6}));
      press(5);
      idle(20);
      check("after_ovf_letter", 32'({overflow, len, code}), 32'({1'b0, 3'd1, 6'd1}));

      // Key pressed during the word-gap wait: no wg for the first letter.
      clr_counts();
      press(2);
      gap(7);
      press(5);
      idle(20);
      check("lgap_lv_count", 32'(n_lv), 32'd2);
      check("lgap_wg_count", 32'(n_wg), 32'd1);
      check("lgap_second", 32'({len, code}), 32'({3'd1, 6'd1}));

      // Ticks stopped mid-gap: no letter gap until they resume.
      clr_counts();
      press(2);
      repeat (3) step(1'b0, 1'b1);
      repeat (50) step(1'b0, 1'b0);
      check("tick_hold_no_lg", 32'(n_lg), 32'd0);
      idle(20);
      check("tick_resume_lg", 32'(n_lg), 32'd1);

      // Reset during the second element's press discards the partial letter.
      clr_counts();
      press(5);
      gap(2);
      repeat (3) step(1'b1, 1'b1);
      reset_mid();
      idle(3);
      press(2); gap(2); press(5);
      idle(20);
      check("rst_letter", 32'({overflow, len, code}), 32'({1'b0, 3'd2, 6'd1}));
      check("rst_lv_count", 32'(n_lv), 32'd1);
      check("rst_dash_count", 32'(n_dash), 32'd2);

      // Random key runs with random tick density and occasional resets.
      lvl = 1'b0;
      for (int r = 0; r < 320; r++) begin
         run_len = $urandom_range(1, 16);
         dens = $urandom_range(1, 4);
         for (int k = 0; k < run_len; k++) step(lvl, ($urandom_range(0, 3) < dens));
         lvl = ~lvl;
         if ($urandom_range(0, 59) == 0) begin
            reset_mid();
            lvl = 1'b0;
         end
      end
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
